usb_tx_sequencer: RTL

Packet-level transmit controller for the USB-style serial TX path. Generates the bit-time strobe (`send_next_bit`) and timer enable (`Tim_en`) that drive the bit stuffer, and serialises SYNC, PID, payload bytes from the TX FIFO, optional CRC16 and EOP into the stuffer's `data_bit` input. Honours the stuffer's `shift_enable` so inserted stuff bits stall the sequence. Sits between the TX FIFO/packet registers and the bit stuffer/NRZI encoder.

---
 rtl/usb_tx_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_sequencer.sv
// USB TX packet sequencer: serialises SYNC, PID, FIFO payload, optional CRC16 and EOP
// into the bit stuffer. Define USB_TX_CRC16_EN to append a CRC16 field after the payload.
module usb_tx_sequencer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_byte_count,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       shift_enable,
    output logic       send_next_bit,
    output logic       Tim_en,
    output logic       data_bit,
    output logic       eop_se0,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int              TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]      MAX_COUNT = 7'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [4:0]      bits_q, bits_d;
    logic [3:0]      pid_q, pid_d;
    logic [6:0]      bytes_q, bytes_d;
    logic            fifo_rd_q, fifo_rd_d;
    logic            send_next_bit_q, send_next_bit_d;
    logic            tim_en_q, tim_en_d;
    logic            data_bit_q, data_bit_d;
    logic            eop_se0_q, eop_se0_d;
    logic            tx_busy_q, tx_busy_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_error_q, tx_error_d;
    logic            advance, bit_end, go_eop;
`ifdef USB_TX_CRC16_EN
    logic [15:0]     crc_q, crc_d, crc_next;
`endif

    // A stuff bit (shift_enable low) consumes the strobe without moving the sequence.
    assign advance = send_next_bit_q & shift_enable;
    assign bit_end = (timer_q == TIMER_MAX);

`ifdef USB_TX_CRC16_EN
    always_comb begin
        crc_next = (crc_q >> 1) ^ ((crc_q[0] ^ shreg_q[0]) ? 16'hA001 : 16'h0000);
    end
`endif

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path infers a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        shreg_d    = shreg_q;
        bits_d     = bits_q;
        pid_d      = pid_q;
        bytes_d    = bytes_q;
        fifo_rd_d  = 1'b0;
        tx_error_d = 1'b0;
        go_eop     = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d      = crc_q;
`endif
        if (state_q != IDLE && state_q != DONE)
            timer_d = bit_end ? '0 : timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = SYNC;
                    timer_d = '0;
                    shreg_d = 16'h0080;
                    bits_d  = 5'd8;
                    pid_d   = tx_pid;
                    bytes_d = (tx_byte_count > MAX_COUNT) ? MAX_COUNT : tx_byte_count;
`ifdef USB_TX_CRC16_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            SYNC, PID, DATA, CRC: begin
                if (advance) begin
                    shreg_d = shreg_q >> 1;
                    bits_d  = bits_q - 1'b1;
`ifdef USB_TX_CRC16_EN
                    if (state_q == DATA)
                        crc_d = crc_next;
`endif
                    if (bits_q == 5'd1) begin
                        if (state_q == SYNC) begin
                            state_d = PID;
                            shreg_d = {8'h00, ~pid_q, pid_q};
                            bits_d  = 5'd8;
                        end else if (state_q != CRC && bytes_q != 7'd0) begin
                            if (fifo_empty) begin
                                tx_error_d = 1'b1;
                                go_eop     = 1'b1;
                            end else begin
                                state_d   = DATA;
                                shreg_d   = {8'h00, fifo_data};
                                bits_d    = 5'd8;
                                bytes_d   = bytes_q - 1'b1;
                                fifo_rd_d = 1'b1;
                            end
                        end else if (state_q != CRC) begin
`ifdef USB_TX_CRC16_EN
                            // crc_d already includes the final payload bit here.
                            state_d = CRC;
                            shreg_d = ~crc_d;
                            bits_d  = 5'd16;
`else
                            go_eop  = 1'b1;
`endif
                        end else begin
                            go_eop = 1'b1;
                        end
                    end
                end
            end
            EOP: begin
                if (bit_end) begin
                    bits_d = bits_q - 1'b1;
                    if (bits_q == 5'd1)
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_eop) begin
            state_d = EOP;
            timer_d = '0;
            bits_d  = 5'd3;
        end

        // Outputs are registered copies of what the next state implies.
        tim_en_d        = (state_d inside {SYNC, PID, DATA, CRC});
        send_next_bit_d = tim_en_d && (timer_d == TIMER_MAX);
        data_bit_d      = tim_en_d ? shreg_d[0] : 1'b1;
        eop_se0_d       = (state_d == EOP) && (bits_d != 5'd1);
        tx_busy_d       = (state_d != IDLE);
        tx_done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            shreg_q         <= '0;
            bits_q          <= '0;
            pid_q           <= '0;
            bytes_q         <= '0;
            fifo_rd_q       <= 1'b0;
            send_next_bit_q <= 1'b0;
            tim_en_q        <= 1'b0;
            data_bit_q      <= 1'b1;
            eop_se0_q       <= 1'b0;
            tx_busy_q       <= 1'b0;
            tx_done_q       <= 1'b0;
            tx_error_q      <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q           <= 16'hFFFF;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q         <= state_d;
            timer_q         <= timer_d;
            shreg_q         <= shreg_d;
            bits_q          <= bits_d;
            pid_q           <= pid_d;
            bytes_q         <= bytes_d;
            fifo_rd_q       <= fifo_rd_d;
            send_next_bit_q <= send_next_bit_d;
            tim_en_q        <= tim_en_d;
            data_bit_q      <= data_bit_d;
            eop_se0_q       <= eop_se0_d;
            tx_busy_q       <= tx_busy_d;
            tx_done_q       <= tx_done_d;
            tx_error_q      <= tx_error_d;
`ifdef USB_TX_CRC16_EN
            crc_q           <= crc_d;
`endif
        end
    end

    assign fifo_rd       = fifo_rd_q;
    assign send_next_bit = send_next_bit_q;
    assign Tim_en        = tim_en_q;
    assign data_bit      = data_bit_q;
    assign eop_se0       = eop_se0_q;
    assign tx_busy       = tx_busy_q;
    assign tx_done       = tx_done_q;
    assign tx_error      = tx_error_q;

endmodule
